spi_mem_loader: RTL and testbench

SPI slave (mode 0) that owns port A of dual_port_ram and acts as its host-side writer/reader, while Processador uses port B. An external master downloads program words into RAM and reads RAM back for checking, replacing direct bench pokes of port A. The master holds Processador in reset while `busy` is high.

---
 rtl/spi_loader_pkg.sv | 16 +
 rtl/spi_mem_loader_if.sv | 29 ++
 rtl/spi_sync_edge.sv | 60 ++++++
 rtl/spi_mem_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_loader_pkg.sv
// Shared command codes and state encoding for the SPI memory loader.
package spi_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } loader_state_t;

endpackage

// File: rtl/spi_mem_loader_if.sv
// Port A bus of dual_port_ram as seen by the SPI loader (master) and the RAM (slave).
interface spi_mem_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer chains for the asynchronous SPI pins plus sclk/cs_n edge detection.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_cs_n,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES:0]   w_sclk_shift;
    logic [SYNC_STAGES:0]   w_cs_shift;
    logic [SYNC_STAGES:0]   w_mosi_shift;
    logic                   w_sclk_s;
    logic                   w_cs_s;

    assign w_sclk_shift = {r_sclk_sync, i_sclk};
    assign w_cs_shift   = {r_cs_sync, i_cs_n};
    assign w_mosi_shift = {r_mosi_sync, i_mosi};

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

    // cs_n resets to the deselected level so busy is low out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= w_sclk_shift[SYNC_STAGES-1:0];
            r_cs_sync   <= w_cs_shift[SYNC_STAGES-1:0];
            r_mosi_sync <= w_mosi_shift[SYNC_STAGES-1:0];
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign o_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign o_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign o_cs_fall   = ~w_cs_s & r_cs_d;
    assign o_cs_rise   = w_cs_s & ~r_cs_d;
    assign o_cs_n      = w_cs_s;
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that writes program words into RAM port A and reads them back.
module spi_mem_loader
    import spi_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic load_done,
    output logic cmd_err,
    spi_mem_loader_if.master mem
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TXC_W  = $clog2(DATA_WIDTH);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_cs_n_s;
    logic w_mosi_s;

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_byte_sr;
    logic [BIDX_W-1:0]     r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_prefetch;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TXC_W-1:0]      r_tx_bits;
    logic                  r_rise_seen;
    logic                  r_rd_wait;
    logic                  r_rd_first;
    logic                  r_is_write;
    logic                  r_wrote_any;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_load_done;
    logic                  r_cmd_err;

    logic [7:0]            w_byte_next;
    logic                  w_byte_done;
    logic [DATA_WIDTH-1:0] w_word_next;
    logic                  w_issue_write;
    logic                  w_issue_first_rd;
    logic                  w_word_end;
    logic                  w_set_err;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock      (clock),
        .reset      (reset),
        .i_sclk     (sclk),
        .i_cs_n     (cs_n),
        .i_mosi     (mosi),
        .o_sclk_rise(w_sclk_rise),
        .o_sclk_fall(w_sclk_fall),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_cs_n     (w_cs_n_s),
        .o_mosi     (w_mosi_s)
    );

    assign w_byte_next = {r_byte_sr, w_mosi_s};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_word_next = (r_word << 8) | DATA_WIDTH'(w_byte_next);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cs_n rise wins over everything, including an sclk edge in the same cycle.
    always_comb begin
        w_state_next     = r_state;
        w_issue_write    = 1'b0;
        w_issue_first_rd = 1'b0;
        w_word_end       = 1'b0;
        w_set_err        = 1'b0;
        if (w_cs_rise) begin
            w_state_next = IDLE;
        end else if (w_cs_fall) begin
            w_state_next = CMD;
        end else begin
            case (r_state)
                CMD: begin
                    if (w_byte_done) begin
                        if (w_byte_next == CMD_WRITE || w_byte_next == CMD_READ) begin
                            w_state_next = ADDR;
                        end else begin
                            w_state_next = IGNORE;
                            w_set_err    = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (w_byte_done) begin
                        if (r_is_write) begin
                            w_state_next = WDATA;
                        end else begin
                            w_state_next     = RDATA;
                            w_issue_first_rd = 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (w_byte_done && r_byte_idx == BIDX_W'(NBYTES - 1)) begin
                        w_issue_write = 1'b1;
                    end
                end
                RDATA: begin
                    if (w_sclk_fall && r_rise_seen && r_tx_bits == TXC_W'(DATA_WIDTH - 1)) begin
                        w_word_end = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_byte_sr   <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_tx        <= '0;
            r_prefetch  <= '0;
            r_addr      <= '0;
            r_tx_bits   <= '0;
            r_rise_seen <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_rd_first  <= 1'b0;
            r_is_write  <= 1'b0;
            r_wrote_any <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_done <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;
            r_rd_wait   <= r_mem_en && !r_mem_we;
            if (w_cs_rise) begin
                r_load_done <= r_wrote_any;
                r_wrote_any <= 1'b0;
            end else if (w_cs_fall) begin
                r_bit_cnt   <= '0;
                r_byte_sr   <= '0;
                r_byte_idx  <= '0;
                r_word      <= '0;
                r_tx        <= '0;
                r_tx_bits   <= '0;
                r_rise_seen <= 1'b0;
                r_rd_first  <= 1'b0;
                r_wrote_any <= 1'b0;
                r_cmd_err   <= 1'b0;
            end else begin
                if (w_sclk_rise && r_state != IDLE) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_byte_sr <= w_byte_next[6:0];
                end
                if (r_state == CMD && w_byte_done) begin
                    r_is_write <= (w_byte_next == CMD_WRITE);
                end
                if (w_set_err) begin
                    r_cmd_err <= 1'b1;
                end
                if (r_state == ADDR && w_byte_done) begin
                    r_addr <= w_byte_next[ADDR_WIDTH-1:0];
                end
                if (r_state == WDATA && w_byte_done) begin
                    r_word     <= w_word_next;
                    r_byte_idx <= w_issue_write ? '0 : r_byte_idx + 1'b1;
                end
                if (w_issue_write) begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= w_word_next;
                    r_addr      <= r_addr + 1'b1;
                    r_wrote_any <= 1'b1;
                end
                if (w_issue_first_rd) begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= w_byte_next[ADDR_WIDTH-1:0];
                    r_rd_first <= 1'b1;
                end
                // miso only shifts on a fall that follows a data-phase rise.
                if (r_state == RDATA) begin
                    if (w_sclk_rise) begin
                        r_rise_seen <= 1'b1;
                    end else if (w_sclk_fall && r_rise_seen) begin
                        r_rise_seen <= 1'b0;
                        r_tx_bits   <= w_word_end ? '0 : r_tx_bits + 1'b1;
                        r_tx        <= w_word_end ? r_prefetch : (r_tx << 1);
                    end
                    if (r_rd_wait) begin
                        if (r_rd_first) begin
                            r_tx       <= mem.mem_rdata;
                            r_rd_first <= 1'b0;
                        end else begin
                            r_prefetch <= mem.mem_rdata;
                        end
                    end
                    if ((r_rd_wait && r_rd_first) || w_word_end) begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_addr + 1'b1;
                        r_addr     <= r_addr + 1'b1;
                    end
                end
            end
        end
    end

    assign miso          = (r_state == RDATA) ? r_tx[DATA_WIDTH-1] : 1'b0;
    assign busy          = ~w_cs_n_s;
    assign load_done     = r_load_done;
    assign cmd_err       = r_cmd_err;
    assign mem.mem_en    = r_mem_en;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: SPI master driver, port-A RAM and a transaction-level memory model.
module tb_spi_mem_loader;

    localparam int HALF = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso;
    logic busy;
    logic load_done;
    logic cmd_err;

    spi_mem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) mif ();

    spi_mem_loader #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .busy     (busy),
        .load_done(load_done),
        .cmd_err  (cmd_err),
        .mem      (mif)
    );

    always #5 clock = ~clock;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [39:0] exp_q [$];
    logic [39:0] cmp_e;
    logic [7:0]  wbuf [0:15];
    logic [31:0] rd_words [0:7];
    logic [7:0]  wr_addrs [$];
    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int ld_cnt = 0;
    bit rd_allowed = 1'b0;

    // Port A of the RAM: registered read, data valid one clock after mem_en.
    always @(posedge clock) begin
        if (mif.mem_en === 1'b1) begin
            if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
            else            mif.mem_rdata <= ram[mif.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mif.mem_en === 1'b1) begin
            if (mif.mem_we) begin
                wr_cnt++;
                chk("wr_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cmp_e = exp_q.pop_front();
                    chk("wr_addr", 64'(mif.mem_addr), 64'(cmp_e[39:32]));
                    chk("wr_data", 64'(mif.mem_wdata), 64'(cmp_e[31:0]));
                end
            end else begin
                chk("rd_window", 64'(rd_allowed), 64'd1);
            end
        end
        if (load_done === 1'b1) ld_cnt++;
        if (!rd_allowed) chk("miso_idle", 64'(miso), 64'd0);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] d;
        xfer(b, d);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(HALF);
        chk("busy_on", 64'(busy), 64'd1);
        chk("cmd_err_clr", 64'(cmd_err), 64'd0);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(3 * HALF);
        chk("busy_off", 64'(busy), 64'd0);
    endtask

    task automatic write_txn(input logic [7:0] a, input int nb);
        int ld0 = ld_cnt;
        int wr0 = wr_cnt;
        int nw  = nb / 4;
        logic [31:0] w;
        for (int k = 0; k < nw; k++) begin
            w = {wbuf[4*k], wbuf[4*k+1], wbuf[4*k+2], wbuf[4*k+3]};
            exp_q.push_back({8'(a + k), w});
            ref_mem[8'(a + k)] = w;
        end
        cs_begin();
        send(8'h02);
        send(a);
        for (int i = 0; i < nb; i++) send(wbuf[i]);
        cs_end();
        chk("load_done", 64'(ld_cnt - ld0), (nw > 0) ? 64'd1 : 64'd0);
        chk("wr_count", 64'(wr_cnt - wr0), 64'(nw));
        chk("wr_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic read_txn(input logic [7:0] a, input int nw);
        logic [7:0]  b;
        logic [31:0] w;
        w = '0;
        rd_allowed = 1'b1;
        cs_begin();
        send(8'h03);
        send(a);
        for (int k = 0; k < nw; k++) begin
            for (int j = 0; j < 4; j++) begin
                xfer(8'h00, b);
                w = {w[23:0], b};
            end
            rd_words[k] = w;
            chk("rd_word", 64'(w), 64'(ref_mem[8'(a + k)]));
        end
        cs_end();
        rd_allowed = 1'b0;
    endtask

    initial begin
        #900_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ld0;
        int wr0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        wait_clk(4);
        chk("rst_outs", 64'({miso, busy, load_done, cmd_err, mif.mem_en, mif.mem_we}), 64'd0);
        chk("rst_addr", 64'(mif.mem_addr), 64'd0);
        chk("rst_wdata", 64'(mif.mem_wdata), 64'd0);
        reset = 1'b1;
        wait_clk(4);

        // Program download followed by readback.
        wr0 = wr_cnt;
        {wbuf[0], wbuf[1], wbuf[2],  wbuf[3]}  = 32'h00001000;
        {wbuf[4], wbuf[5], wbuf[6],  wbuf[7]}  = 32'h00001210;
        {wbuf[8], wbuf[9], wbuf[10], wbuf[11]} = 32'h00009312;
        write_txn(8'h00, 12);
        chk("prog_pulses", 64'(wr_cnt - wr0), 64'd3);
        chk("model_m2", 64'(ref_mem[2]), 64'h00009312);
        read_txn(8'h00, 3);
        chk("lit_w0", 64'(rd_words[0]), 64'h00001000);
        chk("lit_w1", 64'(rd_words[1]), 64'h00001210);
        chk("lit_w2", 64'(rd_words[2]), 64'h00009312);

        // Address wrap 0xFF -> 0x00.
        {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'hAABBCCDD;
        {wbuf[4], wbuf[5], wbuf[6], wbuf[7]} = 32'h11223344;
        write_txn(8'hFF, 8);
        read_txn(8'hFF, 2);
        chk("lit_wrap_ff", 64'(rd_words[0]), 64'hAABBCCDD);
        chk("lit_wrap_00", 64'(rd_words[1]), 64'h11223344);

        // Partial word discarded.
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h7E;
        write_txn(8'h10, 3);
        read_txn(8'h10, 1);
        chk("lit_abort", 64'(rd_words[0]), 64'd0);

        // Illegal command, then a normal write.
        ld0 = ld_cnt;
        wr0 = wr_cnt;
        cs_begin();
        send(8'hA5);
        for (int i = 0; i < 8; i++) send(8'($urandom));
        cs_end();
        chk("cmd_err_set", 64'(cmd_err), 64'd1);
        chk("ill_load_done", 64'(ld_cnt - ld0), 64'd0);
        chk("ill_writes", 64'(wr_cnt - wr0), 64'd0);
        {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'hCAFE0123;
        write_txn(8'h20, 4);
        read_txn(8'h20, 1);
        chk("lit_after_ill", 64'(rd_words[0]), 64'hCAFE0123);

        // Reset in the middle of a word.
        ld0 = ld_cnt;
        wr0 = wr_cnt;
        cs_begin();
        send(8'h02);
        send(8'h40);
        send(8'hAA);
        send(8'hBB);
        reset = 1'b0;
        wait_clk(2);
        chk("rst_mid_outs", 64'({miso, busy, load_done, cmd_err, mif.mem_en, mif.mem_we}), 64'd0);
        chk("rst_mid_addr", 64'(mif.mem_addr), 64'd0);
        chk("rst_mid_wdata", 64'(mif.mem_wdata), 64'd0);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        chk("rst_mid_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("rst_mid_ld", 64'(ld_cnt - ld0), 64'd0);
        {wbuf[0], wbuf[1], wbuf[2], wbuf[3]} = 32'h11223344;
        write_txn(8'h05, 4);
        read_txn(8'h05, 1);
        chk("lit_post_rst", 64'(rd_words[0]), 64'h11223344);
        read_txn(8'h40, 1);

        // Randomized downloads of whole and partial words, then readback.
        for (int t = 0; t < 6; t++) begin
            logic [7:0] a;
            int nb;
            a  = 8'($urandom);
            nb = $urandom_range(1, 13);
            for (int i = 0; i < nb; i++) wbuf[i] = 8'($urandom);
            wr_addrs.push_back(a);
            write_txn(a, nb);
        end
        for (int t = 0; t < 6; t++) begin
            read_txn(wr_addrs[t], $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
